unified_mem_arbiter: RTL

- Shares one single-port, 1-cycle-read-latency unified memory between the core's instruction fetch unit (IFU) and load/store unit (LSU).
- Sits between the core pipeline and the memory macro inside toplevel, replacing the separate instruction and data memory ports.
- Fixed LSU priority with a starvation guard, so fetch always makes progress.
- Pipelined: accepts one access per cycle and routes each read response back to its requester.

---
 rtl/unified_mem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port, 1-cycle-latency memory between IFU and
//            LSU: LSU priority with a streak guard, responses routed back.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                      GLOBAL_CLK_IN,
    input  logic                      GLOBAL_RST_N,

    input  logic                      ifu_req,
    input  logic [ADDR_WIDTH-1:0]     ifu_addr,
    output logic                      ifu_gnt,
    output logic                      ifu_rvalid,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,

    input  logic                      lsu_req,
    input  logic                      lsu_we,
    input  logic [DATA_WIDTH/8-1:0]   lsu_be,
    input  logic [ADDR_WIDTH-1:0]     lsu_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    output logic                      lsu_gnt,
    output logic                      lsu_rvalid,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,

    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [ADDR_WIDTH-3:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam logic [3:0] c_MAX_STREAK = 4'(MAX_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

    owner_t     r_resp_owner;
    logic       r_resp_is_store;
    logic [3:0] r_streak;

    logic       w_lsu_win;
    logic       w_ifu_win;
    logic       w_unused;

    // Reset gates the grants so nothing reaches memory while held in reset.
    always_comb begin
        w_lsu_win = GLOBAL_RST_N && lsu_req && (!ifu_req || (r_streak < c_MAX_STREAK));
        w_ifu_win = GLOBAL_RST_N && ifu_req && !w_lsu_win;
    end

    assign ifu_gnt   = w_ifu_win;
    assign lsu_gnt   = w_lsu_win;
    assign mem_en    = w_ifu_win | w_lsu_win;
    assign mem_addr  = w_lsu_win ? lsu_addr[ADDR_WIDTH-1:2] : ifu_addr[ADDR_WIDTH-1:2];
    assign mem_we    = (w_lsu_win && lsu_we) ? lsu_be : '0;
    assign mem_wdata = lsu_wdata;

    assign w_unused  = ^{ifu_addr[1:0], lsu_addr[1:0]};

    always_ff @(posedge GLOBAL_CLK_IN) begin
        if (!GLOBAL_RST_N) begin
            r_resp_owner    <= OWN_NONE;
            r_resp_is_store <= 1'b0;
            r_streak        <= 4'd0;
        end else begin
            if (w_ifu_win) begin
                r_resp_owner <= OWN_IFU;
            end else if (w_lsu_win) begin
                r_resp_owner <= OWN_LSU;
            end else begin
                r_resp_owner <= OWN_NONE;
            end

            if (w_lsu_win) begin
                r_resp_is_store <= lsu_we;
            end

            // Count LSU wins only while the IFU is left waiting.
            if (w_ifu_win || !ifu_req) begin
                r_streak <= 4'd0;
            end else if (w_lsu_win && (r_streak < c_MAX_STREAK)) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

    // A response in flight when reset asserts is dropped immediately.
    assign ifu_rvalid = GLOBAL_RST_N && (r_resp_owner == OWN_IFU);
    assign lsu_rvalid = GLOBAL_RST_N && (r_resp_owner == OWN_LSU);
    assign ifu_rdata  = mem_rdata;
    assign lsu_rdata  = r_resp_is_store ? '0 : mem_rdata;

endmodule
`default_nettype wire
